alu_serial_sequencer: RTL and testbench
=======================================

// Module: alu_serial_sequencer
// PURPOSE
//  Driver/collector for the bit-serial 1-bit ALU. Accepts two parallel operands and an
//  op code via valid/ready, streams them LSB-first into the ALU (rs1/rs2/alu_enable/
//  alu_start), shifts the registered serial result back into a parallel word, and
//  presents it on a valid/ready result port. Sits between decode/regfile and the ALU.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2); sets shift length and counter size
// PORTS
//  clk         in   1      clock; all logic on posedge
//  rst_n       in   1      reset, synchronous, active-low
//  op_valid    in   1      operand request valid
//  op_ready    out  1      sequencer can accept request (high only in IDLE)
//  op_a        in   WIDTH  operand A (drives alu_rs1)
//  op_b        in   WIDTH  operand B (drives alu_rs2)
//  op_code     in   3      000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, other -> result 0
//  alu_rs1     out  1      serial A bit to ALU
//  alu_rs2     out  1      serial B bit to ALU
//  alu_op      out  3      op code to ALU, held constant PRIME..DRAIN
//  alu_enable  out  1      ALU bit-step enable
//  alu_start   out  1      ALU carry-prime strobe
//  alu_result  in   1      registered serial result bit from ALU
//  res_valid   out  1      result word valid
//  res_ready   in   1      consumer accepts result
//  res_data    out  WIDTH  result word
//  busy        out  1      high in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; all outputs 0 except op_ready=1; operand
//    shift regs, result reg, bit counter cleared. Reset mid-operation aborts, no result.
//  - States: IDLE -> PRIME -> SHIFT (WIDTH cycles) -> DRAIN -> DONE -> IDLE.
//  - IDLE: op_ready=1. op_valid&&op_ready at posedge latches op_a/op_b/op_code, -> PRIME.
//  - PRIME (1 cycle): alu_enable=1, alu_start=1, alu_rs1=alu_rs2=0. Clears ALU carry for
//    ADD, sets carry=1 for SUB; ALU result produced this cycle is discarded.
//  - SHIFT cycle i (i=0..WIDTH-1): alu_enable=1, alu_start=0, alu_rs1=A[i], alu_rs2=B[i];
//    operand regs shift right each cycle. Counter counts 0..WIDTH-1, -> DRAIN after i=WIDTH-1.
//  - Result capture: alu_result is one cycle late; at posedges ending SHIFT cycles 1..WIDTH-1
//    and DRAIN, res_data <= {alu_result, res_data[WIDTH-1:1]} (exactly WIDTH shifts).
//  - DRAIN (1 cycle): alu_enable=0, alu_start=0, rs1=rs2=0; last bit captured -> DONE.
//  - DONE: res_valid=1, res_data stable; res_valid&&res_ready at posedge -> IDLE,
//    res_valid drops. res_ready low holds DONE indefinitely; no new request accepted.
//  - Latency: accepting posedge E0; res_valid=1 after posedge E(WIDTH+2).
//    Minimum request-to-request spacing WIDTH+4 cycles (one IDLE cycle between ops).
//  - alu_rs1/alu_rs2/alu_enable/alu_start registered outputs (glitch-free); alu_op=0 in IDLE.
//  - Arithmetic wraps modulo 2^WIDTH; final carry/borrow not observed or reported.
//  - Unsupported op_code passed through unchanged; ALU yields 0 -> res_data=0.
//  - op_a/op_b/op_code changes after acceptance have no effect on current operation.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN defined: extra outputs res_zero (1) and res_neg (1), valid with
//    res_valid; res_zero=1 iff all captured bits 0 (running OR during capture, inverted),
//    res_neg=res_data[WIDTH-1]; both cleared by reset and on leaving DONE.
//  Not defined: ports res_zero/res_neg absent; no flag logic synthesized.
// TESTING  (WIDTH=8, sequencer wired to alu_1bit, shared clk/rst_n)
//  - ADD 0x35+0x4A -> res_data=0x7F, res_valid exactly 10 posedges after accept.
//  - SUB 0x10-0x01 -> 0x0F; then SUB 0x00-0x01 -> 0xFF (wrap; res_neg=1 if flags on).
//  - SUB 0x05-0x03 then immediately ADD 0xFF+0x01 -> 0x02 then 0x00 (carry re-primed;
//    res_zero=1 if flags on).
//  - XOR/AND/OR 0xC3,0x5A -> 0x99/0x42/0xDB; op_code 3'b111 -> 0x00.
//  - res_ready low 5 cycles in DONE -> res_valid/res_data held, op_ready=0, op_valid
//    ignored; release -> IDLE next cycle.
//  - rst_n low during SHIFT i=3 -> next cycle IDLE, op_ready=1, alu_enable=0, res_valid=0;
//    following ADD 0x01+0x01 -> 0x02.

Source files
------------

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU driver: streams operands LSB-first into a 1-bit ALU and reassembles the result word.
// Optional ALU_SEQ_FLAGS_EN adds res_zero/res_neg flag outputs.
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_code,
    output logic             alu_rs1,
    output logic             alu_rs2,
    output logic [2:0]       alu_op,
    output logic             alu_enable,
    output logic             alu_start,
    input  logic             alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             res_zero,
    output logic             res_neg,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PRIME, SHIFT, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_reg;
    logic [CW-1:0]    cnt;
    logic             capture;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_valid)   state_next = PRIME;
            PRIME:                   state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DRAIN;
            DRAIN:                   state_next = DONE;
            DONE:    if (res_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // The ALU result lags its operands by one cycle, so SHIFT cycle 0 carries nothing yet.
    assign capture = ((state == SHIFT) && (cnt != '0)) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            op_reg     <= '0;
            cnt        <= '0;
            res_data   <= '0;
            alu_rs1    <= 1'b0;
            alu_rs2    <= 1'b0;
            alu_enable <= 1'b0;
            alu_start  <= 1'b0;
        end else begin
            alu_enable <= (state_next == PRIME) || (state_next == SHIFT);
            alu_start  <= (state_next == PRIME);
            alu_rs1    <= 1'b0;
            alu_rs2    <= 1'b0;
            if (state == IDLE && op_valid) begin
                a_sh   <= op_a;
                b_sh   <= op_b;
                op_reg <= op_code;
            end
            if (state_next == SHIFT) begin
                alu_rs1 <= a_sh[0];
                alu_rs2 <= b_sh[0];
                a_sh    <= a_sh >> 1;
                b_sh    <= b_sh >> 1;
            end
            if (state == SHIFT) cnt <= cnt + CW'(1);
            else                cnt <= '0;
            if (capture) res_data <= {alu_result, res_data[WIDTH-1:1]};
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic any_one;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_one  <= 1'b0;
            res_zero <= 1'b0;
            res_neg  <= 1'b0;
        end else begin
            if (state == IDLE && op_valid) any_one <= 1'b0;
            else if (capture)              any_one <= any_one | alu_result;
            // Final capture lands on the DRAIN edge; fold that bit in directly.
            if (state == DRAIN) begin
                res_zero <= ~(any_one | alu_result);
                res_neg  <= alu_result;
            end else if (state == DONE && res_ready) begin
                res_zero <= 1'b0;
                res_neg  <= 1'b0;
            end
        end
    end
`endif

    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign alu_op    = (state == PRIME || state == SHIFT || state == DRAIN) ? op_reg : 3'b000;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Bench for alu_serial_sequencer: behavioural 1-bit ALU plus word-level reference model.
module tb_alu_serial_sequencer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid, op_ready;
    logic [W-1:0] op_a, op_b;
    logic [2:0]   op_code;
    logic         alu_rs1, alu_rs2, alu_enable, alu_start, alu_result;
    logic [2:0]   alu_op;
    logic         res_valid, res_ready, busy;
    logic [W-1:0] res_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic         res_zero, res_neg;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_code(op_code),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op),
        .alu_enable(alu_enable), .alu_start(alu_start), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef ALU_SEQ_FLAGS_EN
        .res_zero(res_zero), .res_neg(res_neg),
`endif
        .busy(busy)
    );

    // Registered 1-bit ALU: start primes the carry (1 for SUB), enable steps one bit.
    logic carry;
    always @(posedge clk) begin
        if (!rst_n) begin
            carry      <= 1'b0;
            alu_result <= 1'b0;
        end else if (alu_enable) begin
            if (alu_start) begin
                carry      <= (alu_op == 3'b001);
                alu_result <= 1'b0;
            end else begin
                case (alu_op)
                    3'b000: {carry, alu_result} <= {1'b0, alu_rs1} + {1'b0, alu_rs2} + {1'b0, carry};
                    3'b001: {carry, alu_result} <= {1'b0, alu_rs1} + {1'b0, ~alu_rs2} + {1'b0, carry};
                    3'b010: alu_result <= alu_rs1 ^ alu_rs2;
                    3'b011: alu_result <= alu_rs1 & alu_rs2;
                    3'b100: alu_result <= alu_rs1 | alu_rs2;
                    default: alu_result <= 1'b0;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a ^ b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            default: return '0;
        endcase
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input int stall);
        logic [W-1:0] exp;
        int n;
        exp = ref_op(a, b, op);
        n = 0;
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", op_ready, 1);
        op_valid = 1'b1; op_a = a; op_b = b; op_code = op;
        @(negedge clk);
        op_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); op_code = 3'($urandom);
        chk("prime_strobe", {alu_enable, alu_start}, 2'b11);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 3) chk("alu_op_hold", alu_op, op);
        end
        chk("latency", n, W + 2);
        chk($sformatf("data op%0d %h,%h", op, a, b), res_data, exp);
`ifdef ALU_SEQ_FLAGS_EN
        chk("flag_zero", res_zero, (exp == '0));
        chk("flag_neg", res_neg, exp[W-1]);
`endif
        for (int i = 0; i < stall; i++) begin
            op_valid = 1'b1; op_a = W'($urandom);
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, exp);
            chk("stall_ready", op_ready, 0);
        end
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("release_valid", res_valid, 0);
        chk("release_ready", op_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_code = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_alu", {alu_enable, alu_start, alu_rs1, alu_rs2, alu_op}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h35, 8'h4A, 3'b000, 0);
        run_op(8'h10, 8'h01, 3'b001, 0);
        run_op(8'h00, 8'h01, 3'b001, 0);
        run_op(8'h05, 8'h03, 3'b001, 0);
        run_op(8'hFF, 8'h01, 3'b000, 0);
        run_op(8'hC3, 8'h5A, 3'b010, 0);
        run_op(8'hC3, 8'h5A, 3'b011, 0);
        run_op(8'hC3, 8'h5A, 3'b100, 0);
        run_op(8'hC3, 8'h5A, 3'b111, 0);
        run_op(8'h12, 8'h34, 3'b000, 5);

        // Abort during SHIFT bit 3.
        op_valid = 1'b1; op_a = 8'h77; op_b = 8'h11; op_code = 3'b000;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_en", alu_enable, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", op_ready, 1);
        chk("abort_en", alu_enable, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_data", res_data, 0);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 3'b000, 0);

        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
